// File: rtl/firin_siralayici_if.sv
// Bundle of station request buses, dough-unit handshake and result signals
// shared between the oven sequencer and its environment.
interface firin_siralayici_if #(
    parameter int N_REQ = 4
);
    logic [N_REQ-1:0]   istek;
    logic [6*N_REQ-1:0] un_bus;
    logic [8*N_REQ-1:0] su_bus;
    logic [3*N_REQ-1:0] tuz_bus;
    logic [N_REQ-1:0]   maya_bus;

    logic               h_basla;
    logic [5:0]         h_un;
    logic [7:0]         h_su;
    logic [2:0]         h_tuz;
    logic               h_maya;
    logic [1:0]         h_kalinlik;
    logic               h_mayali;
    logic               h_tuzlu;
    logic               h_bitti;

    logic [N_REQ-1:0]   onay;
    logic [N_REQ-1:0]   hazir;
    logic [1:0]         sonuc_kalinlik;
    logic               sonuc_mayali;
    logic               sonuc_tuzlu;
    logic               hata;
    logic               mesgul;

    // Environment side: stations and the dough unit.
    modport master (
        output istek, un_bus, su_bus, tuz_bus, maya_bus,
        output h_kalinlik, h_mayali, h_tuzlu, h_bitti,
        input  h_basla, h_un, h_su, h_tuz, h_maya,
        input  onay, hazir, sonuc_kalinlik, sonuc_mayali, sonuc_tuzlu, hata, mesgul
    );

    // Sequencer side.
    modport slave (
        input  istek, un_bus, su_bus, tuz_bus, maya_bus,
        input  h_kalinlik, h_mayali, h_tuzlu, h_bitti,
        output h_basla, h_un, h_su, h_tuz, h_maya,
        output onay, hazir, sonuc_kalinlik, sonuc_mayali, sonuc_tuzlu, hata, mesgul
    );
endinterface

// File: rtl/firin_siralayici.sv
// Round-robin sequencer sharing one dough unit among N_REQ stations, followed
// by thickness-scaled proofing and baking timers and a per-station completion pulse.
module firin_siralayici #(
    parameter int N_REQ       = 4,
    parameter int MAYA_SURE   = 16,
    parameter int PISME_SURE  = 8,
    parameter int ZAMAN_ASIMI = 8
) (
    input logic              saat,
    input logic              reset,
    firin_siralayici_if.slave bus
);
    localparam int SW       = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int EN_BUYUK = (MAYA_SURE > PISME_SURE) ? MAYA_SURE : PISME_SURE;
    localparam int SAYAC_UST = (4 * EN_BUYUK > ZAMAN_ASIMI) ? 4 * EN_BUYUK : ZAMAN_ASIMI;
    localparam int CW       = $clog2(SAYAC_UST + 1);

    typedef enum logic [2:0] {BOS, ISTE, MAYALA, PIS, TESLIM, HATA} durum_t;

    durum_t        durum;
    logic [SW-1:0] son;
    logic [CW-1:0] sayac;
    logic [SW-1:0] aday;
    logic          aday_var;

    // Timer reload: (k+1)*taban cycles, counted down to zero; k=3 gives x4.
    function automatic logic [CW-1:0] sure(input logic [1:0] k, input int taban);
        return CW'((int'(k) + 1) * taban - 1);
    endfunction

    // Round-robin search starting just after the last granted station.
    // NOTE: every variable gets a default before the loop so no latch is inferred.
    always_comb begin
        int            idx;
        logic [SW-1:0] idx_k;
        aday     = son;
        aday_var = 1'b0;
        idx      = 0;
        idx_k    = '0;
        for (int ofs = 1; ofs <= N_REQ; ofs++) begin
            idx = int'(son) + ofs;
            if (idx >= N_REQ) idx = idx - N_REQ;
            idx_k = SW'(idx);
            if (!aday_var && bus.istek[idx_k]) begin
                aday     = idx_k;
                aday_var = 1'b1;
            end
        end
    end

    // NOTE: all state and outputs use non-blocking assignments so every
    // register updates from pre-edge values.
    always_ff @(posedge saat) begin
        if (reset) begin
            durum              <= BOS;
            son                <= SW'(N_REQ - 1);
            sayac              <= '0;
            bus.onay           <= '0;
            bus.hazir          <= '0;
            bus.hata           <= 1'b0;
            bus.mesgul         <= 1'b0;
            bus.h_basla        <= 1'b0;
            bus.h_un           <= '0;
            bus.h_su           <= '0;
            bus.h_tuz          <= '0;
            bus.h_maya         <= 1'b0;
            bus.sonuc_kalinlik <= '0;
            bus.sonuc_mayali   <= 1'b0;
            bus.sonuc_tuzlu    <= 1'b0;
        end else begin
            case (durum)
                BOS: begin
                    if (aday_var) begin
                        son         <= aday;
                        bus.h_un    <= bus.un_bus[6*aday +: 6];
                        bus.h_su    <= bus.su_bus[8*aday +: 8];
                        bus.h_tuz   <= bus.tuz_bus[3*aday +: 3];
                        bus.h_maya  <= bus.maya_bus[aday];
                        bus.h_basla <= 1'b1;
                        bus.onay    <= N_REQ'(1) << aday;
                        bus.mesgul  <= 1'b1;
                        sayac       <= '0;
                        durum       <= ISTE;
                    end
                end

                ISTE: begin
                    bus.onay <= '0;
                    if (bus.h_bitti) begin
                        bus.h_basla        <= 1'b0;
                        bus.sonuc_kalinlik <= bus.h_kalinlik;
                        bus.sonuc_mayali   <= bus.h_mayali;
                        bus.sonuc_tuzlu    <= bus.h_tuzlu;
                        if (bus.h_mayali) begin
                            sayac <= sure(bus.h_kalinlik, MAYA_SURE);
                            durum <= MAYALA;
                        end else begin
                            sayac <= sure(bus.h_kalinlik, PISME_SURE);
                            durum <= PIS;
                        end
                    end else if (sayac == CW'(ZAMAN_ASIMI - 1)) begin
                        bus.h_basla        <= 1'b0;
                        bus.sonuc_kalinlik <= '0;
                        bus.sonuc_mayali   <= 1'b0;
                        bus.sonuc_tuzlu    <= 1'b0;
                        bus.hazir          <= N_REQ'(1) << son;
                        bus.hata           <= 1'b1;
                        durum              <= HATA;
                    end else begin
                        sayac <= sayac + 1'b1;
                    end
                end

                MAYALA: begin
                    if (sayac == '0) begin
                        // Captured thickness sets the baking length too.
                        sayac <= sure(bus.sonuc_kalinlik, PISME_SURE);
                        durum <= PIS;
                    end else begin
                        sayac <= sayac - 1'b1;
                    end
                end

                PIS: begin
                    if (sayac == '0) begin
                        bus.hazir <= N_REQ'(1) << son;
                        durum     <= TESLIM;
                    end else begin
                        sayac <= sayac - 1'b1;
                    end
                end

                TESLIM, HATA: begin
                    bus.hazir  <= '0;
                    bus.hata   <= 1'b0;
                    bus.mesgul <= 1'b0;
                    durum      <= BOS;
                end

                default: durum <= BOS;
            endcase
        end
    end
endmodule

// File: doc/firin_siralayici.md
Name: firin_siralayici

Overview:
- Sequencer and arbiter that shares one dough unit (`hamur`) among N_REQ order stations.
- Grants stations round-robin and drives the dough unit's start and ingredient inputs.
- Captures the dough result, then runs a proofing timer (yeasted dough only) and a baking timer, both scaled by thickness.
- Returns the result to the granted station with a one-cycle completion pulse, or a timeout error if the dough unit never reports done.

Parameters:
- N_REQ, 4: number of requesting stations (2..8).
- MAYA_SURE, 16: proofing cycles per thickness step.
- PISME_SURE, 8: baking cycles per thickness step.
- ZAMAN_ASIMI, 8: maximum cycles to wait for h_bitti.

Ports:
- saat  in  1  clock; all logic on rising edge.
- reset  in  1  synchronous, active-high.
- istek  in  N_REQ  per-station request level; held until onay.
- un_bus  in  6*N_REQ  flour per station; station i uses bits [6i+5:6i].
- su_bus  in  8*N_REQ  water per station, 8-bit slices.
- tuz_bus  in  3*N_REQ  salt per station, 3-bit slices.
- maya_bus  in  N_REQ  yeast flag per station.
- h_basla  out  1  start to dough unit.
- h_un  out  6  latched flour to dough unit.
- h_su  out  8  latched water to dough unit.
- h_tuz  out  3  latched salt to dough unit.
- h_maya  out  1  latched yeast flag to dough unit.
- h_kalinlik  in  2  dough unit thickness.
- h_mayali  in  1  dough unit yeasted flag.
- h_tuzlu  in  1  dough unit salted flag.
- h_bitti  in  1  dough unit done.
- onay  out  N_REQ  one-hot grant pulse, 1 cycle.
- hazir  out  N_REQ  one-hot completion pulse, 1 cycle.
- sonuc_kalinlik  out  2  captured thickness.
- sonuc_mayali  out  1  captured yeasted flag.
- sonuc_tuzlu  out  1  captured salted flag.
- hata  out  1  timeout pulse, coincident with hazir.
- mesgul  out  1  high whenever state is not BOS.

Behaviour:
- Reset (synchronous, active-high):
  - All outputs go to 0: onay, hazir, hata, mesgul, h_basla, h_un, h_su, h_tuz, h_maya, sonuc_kalinlik, sonuc_mayali, sonuc_tuzlu.
  - State goes to BOS; counters clear; round-robin pointer son = N_REQ-1, so station 0 has first priority.
  - Reset mid-operation abandons the order silently: no hazir, no hata.
- All outputs are registered.
- States: BOS, ISTE, MAYALA, PIS, TESLIM, HATA.
- BOS:
  - Samples istek each cycle.
  - If any bit is set, grants the first set index searching from son+1 upward, wrapping at N_REQ-1→0.
  - On the grant edge: son←i; latch station i's slices into h_un/h_su/h_tuz/h_maya; set h_basla=1 and onay[i]=1; next state ISTE.
  - onay is high only in the first ISTE cycle.
  - istek is ignored outside BOS. A station that drops istek before being sampled is not granted.
- ISTE:
  - h_basla is held high.
  - When h_bitti is sampled 1: capture h_kalinlik→k, h_mayali and h_tuzlu into the sonuc_* registers; drop h_basla.
  - Next state is MAYALA if h_mayali=1, else PIS.
  - If h_bitti is not sampled 1 within the first ZAMAN_ASIMI ISTE cycles: drop h_basla; next state HATA.
- MAYALA: lasts exactly (k+1)*MAYA_SURE cycles, then PIS.
- PIS: lasts exactly (k+1)*PISME_SURE cycles, then TESLIM.
- Thickness scaling:
  - k=3 (never produced by the dough unit) uses multiplier 4.
  - Counter width must cover 4*max(MAYA_SURE,PISME_SURE) without overflow.
- TESLIM: one cycle with hazir[i]=1; sonuc_* valid; next state BOS.
- HATA: one cycle with hazir[i]=1, hata=1, sonuc_* = 0; next state BOS.
- sonuc_* hold their value between captures.
- h_un/h_su/h_tuz/h_maya hold their latched values until the next grant.
- Latency from the grant-sample cycle t0:
  - onay at t0+1; h_bitti normally at t0+2; timers start t0+3.
  - hazir at t0+3+timer cycles.
  - Earliest next grant-sample is the BOS cycle right after TESLIM/HATA.
- A served station still requesting competes normally in round-robin; it wins again only if no other station requests.

Test Plan:
- Single order, station 0: un=50, su=200, tuz=3, maya=0.
  - Dough unit reports k=2, tuzlu=0.
  - Expect onay[0] at t0+1; PIS 24 cycles (t0+3..t0+26); hazir[0] at t0+27 with sonuc_kalinlik=2, sonuc_mayali=0, sonuc_tuzlu=0; mesgul low at t0+28.
- Yeasted order, station 1: un=30, su=100, tuz=6, maya=1.
  - Dough unit reports k=0, tuzlu=1.
  - Expect MAYALA 16 cycles (t0+3..t0+18), PIS 8 cycles (t0+19..t0+26), hazir[1] at t0+27 with sonuc_mayali=1, sonuc_tuzlu=1.
- Fairness: istek=4'b1111 held continuously → grants in order 0,1,2,3,0; exactly one onay bit per order; no grant while mesgul.
- Timeout: dough model keeps h_bitti=0 for station 2 → h_basla high t0+1..t0+8, then hazir[2]=1, hata=1, sonuc_*=0 at t0+9; BOS at t0+10.
- Reset mid-operation: assert reset during MAYALA for station 3 → next cycle all outputs 0, no hazir; after release with only istek[2] high, station 2 is granted.
- Short request: istek[1] pulsed for 1 cycle while busy → never granted; istek pulsed in a BOS cycle → granted.
